fb_port_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM (1-cycle read latency) between VGA scan-out, a bulk

---
 rtl/fb_port_if.sv | 52 +++++
 rtl/fb_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_if.sv
// Framebuffer arbiter bus: sync/pixel inputs, writer handshake, clear control,
// RAM port and the registered RGB output grouped into one bundle.
interface fb_port_if #(
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 15
);
  // Scan-out position from the sync generator
  logic               pix_tick;
  logic               video_on;
  logic [9:0]         x_loc;
  logic [9:0]         y_loc;
  // Game-logic pixel writer
  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  // Bulk clear engine control
  logic               clear_req;
  logic [COLOR_W-1:0] clear_color;
  logic               clear_busy;
  logic               err_oob;
  // Single-port framebuffer RAM
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic [COLOR_W-1:0] mem_rdata;
  // Pixel to the VGA DAC
  logic [COLOR_W-1:0] rgb;

  // Arbiter side
  modport slave (
    input  pix_tick, video_on, x_loc, y_loc,
    input  wr_valid, wr_addr, wr_data,
    input  clear_req, clear_color,
    input  mem_rdata,
    output wr_ready, clear_busy, err_oob,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output rgb
  );

  // Environment side (sync generator, writer, RAM, DAC)
  modport master (
    output pix_tick, video_on, x_loc, y_loc,
    output wr_valid, wr_addr, wr_data,
    output clear_req, clear_color,
    output mem_rdata,
    input  wr_ready, clear_busy, err_oob,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  rgb
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out reads always win, the bulk
// clear engine fills the buffer in leftover cycles, and the pixel writer gets
// whatever remains while no clear is running.
module fb_port_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int COLOR_W     = 12,
  parameter int ADDR_W      = 15,
  parameter bit VBLANK_ONLY = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  fb_port_if.slave  bus
);

  localparam int                FB_DEPTH  = FB_W * FB_H;
  localparam logic [10:0]       X_LIM     = 11'(FB_W << SCALE_SHIFT);
  localparam logic [10:0]       Y_LIM     = 11'(FB_H << SCALE_SHIFT);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] FB_W_V    = ADDR_W'(FB_W);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0]   clr_color_q, clr_color_d;
  logic                 rd_pend_q, rd_pend_d;     // display read issued last cycle
  logic                 blank_pend_q, blank_pend_d; // blank pixel ticked last cycle
  logic [COLOR_W-1:0]   rgb_q, rgb_d;
  logic                 err_oob_q, err_oob_d;

  logic                 disp_slot;
  logic                 wr_ready;
  logic                 wr_oob;
  logic                 wr_xfer;
  logic [ADDR_W-1:0]    row_ext;
  logic [ADDR_W-1:0]    col_ext;
  logic [ADDR_W-1:0]    row_terms [ADDR_W];
  logic [ADDR_W-1:0]    disp_addr;

  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [COLOR_W-1:0]   mem_wdata;

  // A pixel slot needs a RAM read only when it lands inside the scaled image;
  // rows past the image that video_on still covers are treated as blank.
  assign disp_slot = bus.pix_tick & bus.video_on &
                     ({1'b0, bus.y_loc} < Y_LIM) &
                     ({1'b0, bus.x_loc} < X_LIM);

  assign row_ext = ADDR_W'(bus.y_loc >> SCALE_SHIFT);
  assign col_ext = ADDR_W'(bus.x_loc >> SCALE_SHIFT);

  // row*FB_W as a sum of shifted copies of row, one per set bit of FB_W
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_row_mul
      assign row_terms[gi] = FB_W_V[gi] ? (row_ext << gi) : '0;
    end
  endgenerate

  // Accumulate the shifted row terms and the column into the read address
  always_comb begin
    disp_addr = col_ext;
    for (int i = 0; i < ADDR_W; i++) begin
      disp_addr = disp_addr + row_terms[i];
    end
  end

  // Writer readiness depends only on scan position and FSM state, never on wr_valid
  assign wr_ready = ~rst & (state_q == ST_IDLE) & ~disp_slot &
                    (~VBLANK_ONLY | ~bus.video_on);
  assign wr_oob   = ({1'b0, bus.wr_addr} >= DEPTH_EXT);
  assign wr_xfer  = bus.wr_valid & wr_ready;

  // Grant the single RAM port, advance the clear FSM and the scan-out pipeline
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_color_d  = clr_color_q;
    rd_pend_d    = disp_slot;
    blank_pend_d = bus.pix_tick & ~disp_slot;
    err_oob_d    = 1'b0;
    rgb_d        = rgb_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    // Read data arrives one cycle after the read; blank ticks force black
    if (rd_pend_q) begin
      rgb_d = bus.mem_rdata;
    end else if (blank_pend_q) begin
      rgb_d = '0;
    end

    if (disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (state_q == ST_CLEAR) begin
      mem_en     = 1'b1;
      mem_we     = 1'b1;
      mem_addr   = clr_addr_q;
      mem_wdata  = clr_color_q;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end
    end else if (wr_xfer) begin
      // Out-of-range writes complete the handshake but never touch the RAM
      if (wr_oob) begin
        err_oob_d = 1'b1;
      end else begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = bus.wr_addr;
        mem_wdata = bus.wr_data;
      end
    end

    // A writer transfer in the same cycle still completes; the fill starts next cycle
    if ((state_q == ST_IDLE) && bus.clear_req) begin
      state_d     = ST_CLEAR;
      clr_addr_d  = '0;
      clr_color_d = bus.clear_color;
    end

    if (rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      rd_pend_q    <= 1'b0;
      blank_pend_q <= 1'b0;
      rgb_q        <= '0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_color_q  <= clr_color_d;
      rd_pend_q    <= rd_pend_d;
      blank_pend_q <= blank_pend_d;
      rgb_q        <= rgb_d;
      err_oob_q    <= err_oob_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign bus.err_oob    = err_oob_q;
  assign bus.rgb        = rgb_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the framebuffer.
module tb_fb_port_arbiter;

  localparam int DEPTH = 19200;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, von;
  logic [9:0]  x, y;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        clear_req;
  logic [11:0] clear_color;
  logic [11:0] ram_rdata;
  logic        chk_on;

  int n_tests = 0;
  int n_fail  = 0;

  fb_port_if #(.COLOR_W(12), .ADDR_W(15)) bus ();
  fb_port_if #(.COLOR_W(12), .ADDR_W(15)) bus_vb ();

  assign bus.pix_tick       = tick;
  assign bus.video_on       = von;
  assign bus.x_loc          = x;
  assign bus.y_loc          = y;
  assign bus.wr_valid       = wr_valid;
  assign bus.wr_addr        = wr_addr;
  assign bus.wr_data        = wr_data;
  assign bus.clear_req      = clear_req;
  assign bus.clear_color    = clear_color;
  assign bus.mem_rdata      = ram_rdata;

  assign bus_vb.pix_tick    = tick;
  assign bus_vb.video_on    = von;
  assign bus_vb.x_loc       = x;
  assign bus_vb.y_loc       = y;
  assign bus_vb.wr_valid    = wr_valid;
  assign bus_vb.wr_addr     = wr_addr;
  assign bus_vb.wr_data     = wr_data;
  assign bus_vb.clear_req   = clear_req;
  assign bus_vb.clear_color = clear_color;
  assign bus_vb.mem_rdata   = 12'h000;

  fb_port_arbiter #(.VBLANK_ONLY(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fb_port_arbiter #(.VBLANK_ONLY(1'b1)) u_dut_vb (
    .clk (clk),
    .rst (rst),
    .bus (bus_vb)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      if (n_fail >= 50) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Framebuffer RAM: one access per cycle, read data one cycle later
  logic [11:0] ram [0:DEPTH-1];
  initial begin : ram_model
    for (int i = 0; i < DEPTH; i++) ram[i] = 12'h000;
    ram_rdata = 12'h000;
    forever begin
      @(posedge clk);
      if (bus.mem_en === 1'b1 && int'(bus.mem_addr) < DEPTH) begin
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] = bus.mem_wdata;
        else                     ram_rdata <= ram[bus.mem_addr];
      end
    end
  end

  // Reference model state
  logic [11:0] ref_fb [0:DEPTH-1];
  logic [11:0] rgb_sched [int];
  logic [11:0] rgb_exp = 12'h000;
  logic        clr_active = 1'b0;
  int          clr_addr = 0;
  logic [11:0] clr_color = 12'h000;
  logic        err_exp = 1'b0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          clr_wr_cnt = 0;
  int          disp_busy_cnt = 0;

  initial begin : monitor
    logic        disp, xfer, exp_ready, exp_ready_vb, exp_en, exp_we;
    int          daddr, exp_addr;
    logic [11:0] exp_wdata;
    for (int i = 0; i < DEPTH; i++) ref_fb[i] = 12'h000;
    forever begin
      @(negedge clk);
      if (rgb_sched.exists(cyc)) begin
        rgb_exp = rgb_sched[cyc];
        rgb_sched.delete(cyc);
      end
      disp  = tick && von && (int'(y) < 480) && (int'(x) < 640);
      daddr = (int'(y) / 4) * 160 + int'(x) / 4;
      xfer = 1'b0; exp_en = 1'b0; exp_we = 1'b0; exp_addr = 0; exp_wdata = 12'h000;
      exp_ready    = !rst && !clr_active && !disp;
      exp_ready_vb = exp_ready && !von;
      if (!rst) begin
        if (disp) begin
          exp_en = 1'b1; exp_addr = daddr;
        end else if (clr_active) begin
          exp_en = 1'b1; exp_we = 1'b1; exp_addr = clr_addr; exp_wdata = clr_color;
        end else if (wr_valid && exp_ready) begin
          xfer = 1'b1;
          if (int'(wr_addr) < DEPTH) begin
            exp_en = 1'b1; exp_we = 1'b1; exp_addr = int'(wr_addr); exp_wdata = wr_data;
          end
        end
      end
      if (chk_on) begin
        check_val("wr_ready", 32'(bus.wr_ready), 32'(exp_ready));
        check_val("vb_wr_ready", 32'(bus_vb.wr_ready), 32'(exp_ready_vb));
        check_val("mem_en", 32'(bus.mem_en), 32'(exp_en));
        check_val("mem_we", 32'(bus.mem_we), 32'(exp_we));
        if (exp_en) check_val("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        if (exp_we) check_val("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
        check_val("clear_busy", 32'(bus.clear_busy), 32'(clr_active));
        check_val("err_oob", 32'(bus.err_oob), 32'(err_exp));
        check_val("rgb", 32'(bus.rgb), 32'(rgb_exp));
      end
      if (bus.clear_busy === 1'b1) begin
        busy_cnt++;
        if (disp) disp_busy_cnt++;
        if (bus.mem_we === 1'b1) clr_wr_cnt++;
      end
      // Advance the model across the coming clock edge
      if (rst) begin
        clr_active = 1'b0;
        err_exp    = 1'b0;
        rgb_sched.delete();
        rgb_sched[cyc+1] = 12'h000;
      end else begin
        if (tick) rgb_sched[cyc+2] = disp ? ref_fb[daddr] : 12'h000;
        err_exp = xfer && (int'(wr_addr) >= DEPTH);
        if (xfer && chk_on)
          $display("[TB] cyc %0d writer addr=%0d data=%03h", cyc, wr_addr, wr_data);
        if (xfer && int'(wr_addr) < DEPTH) ref_fb[wr_addr] = wr_data;
        if (clr_active && !disp) begin
          ref_fb[clr_addr] = clr_color;
          if (clr_addr == DEPTH - 1) clr_active = 1'b0;
          else clr_addr++;
        end else if (!clr_active && clear_req) begin
          clr_active = 1'b1;
          clr_addr   = 0;
          clr_color  = clear_color;
        end
      end
      cyc++;
    end
  end

  task automatic wr_pix(input int a, input logic [11:0] d);
    tick = 1'b0; von = 1'b0; wr_valid = 1'b1;
    wr_addr = 15'(a); wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin : stimulus
    int b0, w0, d0, n;
    chk_on = 1'b0;
    rst = 1'b1; tick = 1'b0; von = 1'b0; x = '0; y = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
    step(); step();
    chk_on = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    $display("[TB] display reads of preloaded pixels");
    wr_pix(0, 12'hF00);
    wr_pix(161, 12'h0A5);
    von = 1'b1; tick = 1'b1; x = 10'd0; y = 10'd0; step();
    tick = 1'b0; step();
    tick = 1'b1; x = 10'd4; y = 10'd4; step();
    tick = 1'b0; step(); step(); step();

    $display("[TB] last pixel and blank rows");
    tick = 1'b1; x = 10'd639; y = 10'd479; step();
    tick = 1'b1; x = 10'd0;   y = 10'd485; step();
    tick = 1'b0; step(); step(); step();

    $display("[TB] writer interleaved with scan-out");
    wr_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick = 1'((k % 2) == 0);
      x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
      wr_addr = 15'($urandom_range(0, DEPTH - 1)); wr_data = 12'($urandom);
      step();
    end
    tick = 1'b0; von = 1'b0;
    step(); step(); step();
    wr_valid = 1'b0;

    $display("[TB] clear without scan-out");
    b0 = busy_cnt; w0 = clr_wr_cnt;
    wr_valid = 1'b1; wr_addr = 15'd77; wr_data = 12'h123;
    clear_req = 1'b1; clear_color = 12'h00F; step();
    clear_req = 1'b0;
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 30000) begin
      wr_addr = 15'($urandom_range(0, DEPTH - 1));
      step(); n++;
    end
    wr_valid = 1'b0;
    check_val("clear_done", 32'(bus.clear_busy), 32'd0);
    check_val("clear_busy_cycles", 32'(busy_cnt - b0), 32'd19200);
    check_val("clear_write_count", 32'(clr_wr_cnt - w0), 32'd19200);
    step(); step();

    $display("[TB] clear with scan-out ticks");
    b0 = busy_cnt; d0 = disp_busy_cnt;
    clear_req = 1'b1; clear_color = 12'($urandom); step();
    clear_req = 1'b0; von = 1'b1;
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 40000) begin
      tick = 1'((n % 3) == 0);
      x = 10'($urandom_range(0, 799)); y = 10'($urandom_range(0, 524));
      step(); n++;
    end
    tick = 1'b0; von = 1'b0;
    check_val("clear2_done", 32'(bus.clear_busy), 32'd0);
    check_val("clear2_busy_cycles", 32'(busy_cnt - b0), 32'(19200 + disp_busy_cnt - d0));
    step(); step();

    $display("[TB] out-of-range and last-address writes");
    wr_pix(19200, 12'h123);
    step();
    wr_pix(19199, 12'hABC);
    von = 1'b1; tick = 1'b1; x = 10'd639; y = 10'd479; step();
    tick = 1'b0; step(); step(); step();
    von = 1'b0;

    $display("[TB] reset in the middle of a clear");
    clear_req = 1'b1; clear_color = 12'h5A5; step();
    clear_req = 1'b0;
    for (int k = 0; k < 5000; k++) step();
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    clear_req = 1'b1; clear_color = 12'h0F0; step();
    clear_req = 1'b0;
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1; step(); step();
    rst = 1'b0; step();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 3000; k++) begin
      rst      = 1'($urandom_range(0, 399) == 0);
      tick     = 1'($urandom_range(0, 1));
      von      = 1'($urandom_range(0, 3) != 0);
      x        = 10'($urandom_range(0, 799));
      y        = 10'($urandom_range(0, 524));
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 15'($urandom_range(0, DEPTH + 10));
      wr_data  = 12'($urandom);
      step();
    end
    rst = 1'b0; tick = 1'b0; wr_valid = 1'b0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
